// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite row prefetcher.
// The optional SPRITE_TRANSPARENCY_EN feature keys pixels against TRANSPARENT_KEY.
package sprite_pkg;

    localparam int PIX_W_DEF = 9;

    typedef logic [PIX_W_DEF-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Magenta, packed {R,G,B} = {3'b111, 3'b000, 3'b111}
    localparam pixel_t TRANSPARENT_KEY = 9'h1C7;

endpackage

// File: rtl/sprite_line_buffer.sv
// Double-buffered sprite line store: the fill bank takes ROM returns while the
// active bank is read combinationally by the colour mapper; swap exchanges them.
module sprite_line_buffer #(
    parameter int SPR_W = 32,
    parameter int PIX_W = 9,
    parameter int CW    = $clog2(SPR_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             swap,
    input  logic             we,
    input  logic [CW-1:0]    waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic [CW-1:0]    raddr,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] bank_q [2][SPR_W];
    logic [PIX_W-1:0] bank_d [2][SPR_W];
    logic             sel_q;
    logic             sel_d;

    // Next bank contents and bank-select; writes always land in the non-active bank
    always_comb begin
        bank_d = bank_q;
        if (we) begin
            bank_d[~sel_q][waddr] = wdata;
        end else begin
            bank_d = bank_q;
        end
        if (swap) begin
            sel_d = ~sel_q;
        end else begin
            sel_d = sel_q;
        end
    end

    // Bank-select register
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
        end
    end

    // Pixel storage, intentionally left unreset
    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

    assign rdata = bank_q[sel_q][raddr];

endmodule

// File: rtl/sprite_row_prefetch.sv
// Fetches the next scanline's sprite row from ROM during h-blank into a line buffer.
// Define SPRITE_TRANSPARENCY_EN to make TRANSPARENT_KEY pixels invisible.
module sprite_row_prefetch
    import sprite_pkg::*;
#(
    parameter int SPR_W   = 32,
    parameter int SPR_H   = 32,
    parameter int PIX_W   = 9,
    parameter int ROM_AW  = 10,
    parameter int ROM_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              line_start,
    input  logic [9:0]        NextY,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        SprX,
    input  logic [9:0]        SprY,
    output logic              rom_rd,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic              pix_on,
    output logic [PIX_W-1:0]  pix_data,
    output logic              busy,
    output logic              overrun
);

    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);

    fetch_state_t     state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic             fill_valid_q, fill_valid_d;
    logic             active_valid_q, active_valid_d;
    logic             overrun_q, overrun_d;
    logic [ROM_LAT-1:0] pv_q, pv_d;
    logic [CW-1:0]    pc_q [ROM_LAT];
    logic [CW-1:0]    pc_d [ROM_LAT];

    logic [9:0]       row_full_s;
    logic             row_hit_s;
    logic             we_s;
    logic             last_ret_s;
    logic [9:0]       dx_s;
    logic             in_box_s;
    logic             opaque_s;
    logic [PIX_W-1:0] rdata_s;

    assign row_full_s = NextY - SprY;
    assign row_hit_s  = (row_full_s < 10'(SPR_H));
    assign rom_rd     = (state_q == FETCH);
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;
    assign rom_addr   = ROM_AW'({row_q, col_q});
    assign last_ret_s = pv_q[ROM_LAT-1] && (pc_q[ROM_LAT-1] == CW'(SPR_W - 1));

    // Fetch sequencer; line_start overrides everything, including a coincident final return
    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        row_d          = row_q;
        fill_valid_d   = fill_valid_q;
        active_valid_d = active_valid_q;
        overrun_d      = 1'b0;
        we_s           = 1'b0;
        pv_d[0]        = rom_rd;
        pc_d[0]        = col_q;
        for (int i = 1; i < ROM_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pc_d[i] = pc_q[i-1];
        end
        if (line_start) begin
            active_valid_d = fill_valid_q;
            fill_valid_d   = 1'b0;
            overrun_d      = (state_q != IDLE);
            pv_d           = {ROM_LAT{1'b0}};
            col_d          = {CW{1'b0}};
            row_d          = row_full_s[RW-1:0];
            state_d        = row_hit_s ? FETCH : IDLE;
        end else begin
            we_s = pv_q[ROM_LAT-1];
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                FETCH: begin
                    col_d = col_q + CW'(1);
                    if (col_q == CW'(SPR_W - 1)) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = FETCH;
                    end
                end
                DRAIN: begin
                    if (last_ret_s) begin
                        fill_valid_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Sequencer state, return pipe and buffer-valid flags
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= IDLE;
            col_q          <= {CW{1'b0}};
            row_q          <= {RW{1'b0}};
            fill_valid_q   <= 1'b0;
            active_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            pv_q           <= {ROM_LAT{1'b0}};
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            fill_valid_q   <= fill_valid_d;
            active_valid_q <= active_valid_d;
            overrun_q      <= overrun_d;
            pv_q           <= pv_d;
        end
    end

    // Column tags only matter while their valid bit is set, so they need no reset
    always_ff @(posedge Clk) begin
        pc_q <= pc_d;
    end

    sprite_line_buffer #(
        .SPR_W (SPR_W),
        .PIX_W (PIX_W),
        .CW    (CW)
    ) u_buf (
        .clk   (Clk),
        .reset (Reset),
        .swap  (line_start),
        .we    (we_s),
        .waddr (pc_q[ROM_LAT-1]),
        .wdata (rom_data),
        .raddr (dx_s[CW-1:0]),
        .rdata (rdata_s)
    );

    // Pixel lookup: 10-bit modular offset, so a sprite straddling column 1023 wraps to 0
    always_comb begin
        dx_s     = DrawX - SprX;
        in_box_s = (dx_s < 10'(SPR_W));
`ifdef SPRITE_TRANSPARENCY_EN
        opaque_s = (rdata_s != PIX_W'(TRANSPARENT_KEY));
`else
        opaque_s = 1'b1;
`endif
        pix_on = active_valid_q && in_box_s && opaque_s;
        if (pix_on) begin
            pix_data = rdata_s;
        end else begin
            pix_data = {PIX_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_sprite_row_prefetch.sv
// Scoreboard bench for sprite_row_prefetch: expected ROM addresses and pixel
// lookups are queued by the stimulus and checked by an independent monitor.
module tb_sprite_row_prefetch;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       line_start;
    logic [9:0] NextY, DrawX, SprX, SprY;
    logic       rom_rd;
    logic [9:0] rom_addr;
    logic [8:0] rom_data;
    logic       pix_on;
    logic [8:0] pix_data;
    logic       busy;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    logic [9:0] exp_addr_q [$];
    logic [9:0] exp_pix_q  [$];
    logic       probe_en = 1'b0;

    sprite_row_prefetch dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .line_start (line_start),
        .NextY      (NextY),
        .DrawX      (DrawX),
        .SprX       (SprX),
        .SprY       (SprY),
        .rom_rd     (rom_rd),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pix_on     (pix_on),
        .pix_data   (pix_data),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 Clk = ~Clk;

    // Sprite ROM contents; address 165 (row 5, col 5) holds the transparent key
    function automatic logic [8:0] rom_f(input logic [9:0] a);
        logic [9:0] t;
        if (a == 10'd165) return 9'h1C7;
        t = a * 10'd37 + 10'd11;
        return t[8:0];
    endfunction

    // ROM with a two-cycle read latency
    logic       r_p0 = 1'b0, r_p1 = 1'b0;
    logic [9:0] a_p0 = 10'd0, a_p1 = 10'd0;
    always @(posedge Clk) begin
        r_p0 <= rom_rd;
        a_p0 <= rom_addr;
        r_p1 <= r_p0;
        a_p1 <= a_p0;
    end
    assign rom_data = r_p1 ? rom_f(a_p1) : 9'h000;

    // Expected {pix_on, pix_data} for a displayed sprite row
    function automatic logic [9:0] exp_px(input logic [9:0] x, input logic [9:0] sx,
                                          input logic [4:0] row, input bit valid);
        logic [9:0] dx;
        logic [8:0] d;
        bit         on;
        dx = x - sx;
        on = valid && (dx < 10'd32);
        d  = rom_f({row, dx[4:0]});
`ifdef SPRITE_TRANSPARENCY_EN
        if (d == 9'h1C7) on = 1'b0;
`endif
        return on ? {1'b1, d} : 10'h000;
    endfunction

    // Monitor: every ROM strobe and every pixel probe is checked against the queues
    always @(negedge Clk) begin
        if (rom_rd) begin
            total++;
            if (exp_addr_q.size() == 0) begin
                bad++;
                $display("FAIL rom_rd_unexpected: got addr %0d, required no strobe", rom_addr);
            end else begin
                logic [9:0] ea;
                ea = exp_addr_q.pop_front();
                if (rom_addr !== ea) begin
                    bad++;
                    $display("FAIL rom_addr: got %0d, required %0d", rom_addr, ea);
                end
            end
        end
        if (probe_en) begin
            logic [9:0] ep;
            total++;
            ep = exp_pix_q.pop_front();
            if ({pix_on, pix_data} !== ep) begin
                bad++;
                $display("FAIL pixel DrawX=%0d SprX=%0d: got on=%0b data=%0h, required on=%0b data=%0h",
                         DrawX, SprX, pix_on, pix_data, ep[9], ep[8:0]);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic pulse_line(input logic [9:0] ny);
        NextY      = ny;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic push_addrs(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) exp_addr_q.push_back(10'(a));
    endtask

    task automatic probe(input logic [9:0] x, input logic [9:0] e);
        DrawX = x;
        exp_pix_q.push_back(e);
        probe_en = 1'b1;
        @(negedge Clk);
        #1;
        probe_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int exp_n);
        int n;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        chk(name, n, exp_n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; line_start = 1'b0;
        NextY = 10'd0; DrawX = 10'd200; SprX = 10'd200; SprY = 10'd100;
        repeat (3) tick();
        chk("reset_rom_rd", rom_rd, 0);
        chk("reset_busy", busy, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_pix_on", pix_on, 0);
        Reset = 1'b0;
        tick();

        // Reset held 3 cycles in the middle of a fetch
        push_addrs(160, 170);
        pulse_line(10'd105);
        repeat (10) tick();
        Reset = 1'b1;
        repeat (3) tick();
        chk("midreset_rom_rd", rom_rd, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_pix_on", pix_on, 0);
        Reset = 1'b0;
        tick();
        pulse_line(10'd300);
        probe(10'd200, 10'h000);
        chk("midreset_addr_left", exp_addr_q.size(), 0);

        // Full fetch of row 5, then display it
        push_addrs(160, 191);
        pulse_line(10'd105);
        wait_idle("fetch_busy_len", 34);
        chk("fetch_addr_left", exp_addr_q.size(), 0);
        pulse_line(10'd300);
        chk("display_busy", busy, 0);
        probe(10'd200, {1'b1, rom_f(10'd160)});
        probe(10'd199, 10'h000);
        probe(10'd232, 10'h000);
        for (int x = 201; x <= 231; x++) probe(10'(x), exp_px(10'(x), 10'd200, 5'd5, 1'b1));

        // Rows just outside the sprite: no fetch
        pulse_line(10'd99);
        chk("above_busy", busy, 0);
        repeat (3) tick();
        pulse_line(10'd132);
        chk("below_busy", busy, 0);
        repeat (3) tick();
        pulse_line(10'd300);
        probe(10'd200, 10'h000);

        // line_start 10 cycles into a fetch
        push_addrs(160, 170);
        pulse_line(10'd105);
        repeat (10) tick();
        push_addrs(320, 351);
        pulse_line(10'd110);
        chk("abort_overrun_hi", overrun, 1);
        probe(10'd200, 10'h000);
        tick();
        chk("abort_overrun_lo", overrun, 0);
        wait_idle("refetch_busy_len", 33);
        chk("refetch_addr_left", exp_addr_q.size(), 0);
        pulse_line(10'd300);
        for (int x = 200; x <= 231; x++) probe(10'(x), exp_px(10'(x), 10'd200, 5'd10, 1'b1));

        // Sprite near the right edge and across the 10-bit wrap
        SprX = 10'd630;
        probe(10'd629, 10'h000);
        for (int x = 630; x <= 639; x++) probe(10'(x), exp_px(10'(x), 10'd630, 5'd10, 1'b1));
        SprX = 10'd1000;
        probe(10'd1023, exp_px(10'd1023, 10'd1000, 5'd10, 1'b1));
        for (int x = 0; x <= 7; x++) probe(10'(x), exp_px(10'(x), 10'd1000, 5'd10, 1'b1));
        probe(10'd8, 10'h000);
        SprX = 10'd200;

        // line_start coinciding with the final ROM return
        push_addrs(160, 191);
        pulse_line(10'd105);
        repeat (33) tick();
        pulse_line(10'd300);
        chk("lastret_overrun", overrun, 1);
        chk("lastret_busy", busy, 0);
        tick();
        pulse_line(10'd300);
        probe(10'd210, 10'h000);

        // Transparent key at column 5
        push_addrs(160, 191);
        pulse_line(10'd105);
        wait_idle("key_busy_len", 34);
        pulse_line(10'd300);
`ifdef SPRITE_TRANSPARENCY_EN
        probe(10'd205, 10'h000);
`else
        probe(10'd205, {1'b1, 9'h1C7});
`endif
        probe(10'd204, {1'b1, rom_f(10'd164)});
        chk("final_addr_left", exp_addr_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
